pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Parametrised successor of the combinational PC control unit; it owns the PC register and the instruction-fetch sequencing.
- Arbitrates N prioritised redirect sources (ISR entry/return, jump, jr, branch, ...) against pipeline stall.
- Drives a request/grant/response handshake to a variable-latency instruction memory.
- Presents a registered instruction/PC pair to the IF/ID stage, and discards responses made stale by a redirect.

Parameters:
- ADDR_W, 32, PC and memory address width.
- INSTR_W, 32, instruction width.
- NUM_REDIR, 5, number of redirect channels; index 0 has highest priority.
- PC_STEP, 4, sequential PC increment.
- ALIGN_BITS, 2, low target bits forced to zero.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  downstream cannot accept; an instruction is consumed when if_valid=1 and stall=0.
- redir_valid  in  NUM_REDIR  per-channel redirect request.
- redir_target  in  NUM_REDIR*ADDR_W  packed targets; channel k occupies bits [k*ADDR_W +: ADDR_W].
- im_req  out  1  fetch request.
- im_addr  out  ADDR_W  fetch address, equals pc.
- im_gnt  in  1  memory accepts request this cycle.
- im_rvalid  in  1  response valid.
- im_rdata  in  INSTR_W  response instruction.
- if_valid  out  1  instruction valid to IF/ID.
- if_instr  out  INSTR_W  fetched instruction.
- if_pc  out  ADDR_W  address of if_instr.
- redir_taken  out  1  one-cycle pulse: a redirect was applied this cycle.
- redir_sel  out  max(1,$clog2(NUM_REDIR))  winning channel; valid while redir_taken=1.

Behaviour:
- Reset: pc=RESET_PC, state=S_REQ, drop=0, if_valid=0, if_instr=0, if_pc=0. Combinational outputs redir_taken and redir_sel are 0 while reset is high.
- im_req=1 only in S_REQ. im_addr=pc, combinational from the register.
- Redirect selection is combinational:
  - Lowest set index of redir_valid wins.
  - target = redir_target[sel] with [ALIGN_BITS-1:0] forced to 0.
  - redir_taken = |redir_valid.
- Redirect has priority over stall and over sequential advance in every state.
- S_REQ:
  - gnt & !redir → S_WAIT.
  - gnt & redir → pc<=target, drop<=1, S_WAIT.
  - !gnt & redir → pc<=target, stay in S_REQ; im_addr may change while the request is unaccepted.
  - Otherwise stay.
- S_WAIT:
  - rvalid & !drop & !redir → if_instr<=rdata, if_pc<=pc, if_valid<=1, S_HOLD.
  - rvalid & (drop | redir) → data discarded, drop<=0, S_REQ.
  - !rvalid & redir → drop<=1, stay.
  - Any redir in S_WAIT also loads pc<=target.
- S_HOLD:
  - redir → if_valid<=0 (flush), pc<=target, S_REQ.
  - !stall → if_valid<=0, pc<=pc+PC_STEP (mod 2^ADDR_W, wraps silently), S_REQ.
  - stall → all of if_valid, if_instr and if_pc held.
- im_rvalid outside S_WAIT is ignored. At most one request is outstanding.
- Minimum throughput: one instruction per 3 cycles with gnt and rvalid both returned one cycle after request.
- Repeated redirects while drop=1 only update pc; exactly one stale response is discarded.
- Reset mid-operation returns to the reset state. The instruction memory shares the same reset, so no stale response survives it.

Decomposition:
- Package pc_fetch_pkg holds:
  - state encoding S_REQ=2'd0, S_WAIT=2'd1, S_HOLD=2'd2;
  - the RESET_PC default;
  - channel index constants REDIR_ISR=0, REDIR_RETI=1, REDIR_JUMP=2, REDIR_JR=3, REDIR_BRANCH=4.
- One sub-module, redir_prio_mux: parametrised priority encoder plus target mux with alignment masking, purely combinational.

Test Plan:
1. Reset, then gnt/rvalid one cycle after each request, rdata=0xA0+n, no stall → im_addr sequence 0,4,8; if_pc=0,4,8 with if_instr 0xA0,0xA1,0xA2; if_valid high one cycle each.
2. Instruction at pc=0x8 held, stall high 4 cycles → if_valid/if_pc/if_instr stable for 4 cycles; next im_addr=0xC only after stall falls.
3. In S_WAIT (pc=0x10), pulse redir_valid[4] with target 0x103; rvalid arrives 2 cycles later → response dropped, if_valid stays 0, next im_addr=0x100, redir_sel=4.
4. Same cycle redir_valid=5'b10100, targets ch2=0x200, ch4=0x300 → redir_sel=2, pc=0x200.
5. S_HOLD with stall=1 and redir_valid[0]=1 (target 0x80) → if_valid drops next cycle, im_addr=0x80; stall ignored.
6. Set RESET_PC=0xFFFFFFFC, fetch twice → if_pc 0xFFFFFFFC then 0x00000000.
7. Assert reset while in S_WAIT with drop=1 → next cycle: S_REQ, im_addr=RESET_PC, if_valid=0, drop=0.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC/fetch controller.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int unsigned REDIR_ISR    = 0;
    localparam int unsigned REDIR_RETI   = 1;
    localparam int unsigned REDIR_JUMP   = 2;
    localparam int unsigned REDIR_JR     = 3;
    localparam int unsigned REDIR_BRANCH = 4;

endpackage

// File: rtl/redir_prio_mux.sv
// Priority encoder over redirect channels (index 0 wins) with aligned target mux.
module redir_prio_mux #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned NUM_REDIR  = 5,
    parameter int unsigned ALIGN_BITS = 2,
    parameter int unsigned SEL_W      = 3
) (
    input  logic [NUM_REDIR-1:0]        valid_i,
    input  logic [NUM_REDIR*ADDR_W-1:0] target_i,
    output logic                        any_o,
    output logic [SEL_W-1:0]            sel_o,
    output logic [ADDR_W-1:0]           target_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK =
        ~((ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1));

    logic              found;
    logic [ADDR_W-1:0] raw_target;

    always_comb begin
        found      = 1'b0;
        sel_o      = '0;
        raw_target = '0;
        for (int unsigned i = 0; i < NUM_REDIR; i++) begin
            if (valid_i[i] && !found) begin
                found      = 1'b1;
                sel_o      = SEL_W'(i);
                raw_target = target_i[i*ADDR_W +: ADDR_W];
            end
        end
        any_o    = found;
        target_o = raw_target & ALIGN_MASK;
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch sequencer with prioritised redirects
// and stale-response discard toward a variable-latency instruction memory.
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W     = 32,
    parameter int unsigned        INSTR_W    = 32,
    parameter int unsigned        NUM_REDIR  = 5,
    parameter int unsigned        PC_STEP    = 4,
    parameter int unsigned        ALIGN_BITS = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC   = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic [NUM_REDIR-1:0]        redir_valid,
    input  logic [NUM_REDIR*ADDR_W-1:0] redir_target,
    output logic                        im_req,
    output logic [ADDR_W-1:0]           im_addr,
    input  logic                        im_gnt,
    input  logic                        im_rvalid,
    input  logic [INSTR_W-1:0]          im_rdata,
    output logic                        if_valid,
    output logic [INSTR_W-1:0]          if_instr,
    output logic [ADDR_W-1:0]           if_pc,
    output logic                        redir_taken,
    output logic [((NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1)-1:0] redir_sel
);

    localparam int unsigned SEL_W = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               drop_q, drop_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  ifpc_q, ifpc_d;

    logic               redir;
    logic [SEL_W-1:0]   sel;
    logic [ADDR_W-1:0]  target;

    redir_prio_mux #(
        .ADDR_W    (ADDR_W),
        .NUM_REDIR (NUM_REDIR),
        .ALIGN_BITS(ALIGN_BITS),
        .SEL_W     (SEL_W)
    ) u_prio (
        .valid_i (redir_valid),
        .target_i(redir_target),
        .any_o   (redir),
        .sel_o   (sel),
        .target_o(target)
    );

    assign im_req      = (state_q == S_REQ);
    assign im_addr     = pc_q;
    assign if_valid    = valid_q;
    assign if_instr    = instr_q;
    assign if_pc       = ifpc_q;
    assign redir_taken = redir & ~reset;
    assign redir_sel   = reset ? '0 : sel;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        unique case (state_q)
            S_REQ: begin
                if (redir) pc_d = target;
                if (im_gnt) begin
                    state_d = S_WAIT;
                    if (redir) drop_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (redir) pc_d = target;
                // A response racing a redirect is stale, same as one already marked.
                if (im_rvalid) begin
                    if (!drop_q && !redir) begin
                        instr_d = im_rdata;
                        ifpc_d  = pc_q;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end
                end else if (redir) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    valid_d = 1'b0;
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (!stall) begin
                    valid_d = 1'b0;
                    pc_d    = pc_q + ADDR_W'(PC_STEP);
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= '0;
            ifpc_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl; a second instance covers PC wrap.
module tb_pc_fetch_ctrl;
    import pc_fetch_pkg::*;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, stall, im_gnt, im_rvalid;
    logic [4:0]   redir_valid;
    logic [159:0] redir_target;
    logic [31:0]  im_rdata;
    logic         im_req, if_valid, redir_taken;
    logic [31:0]  im_addr, if_instr, if_pc;
    logic [2:0]   redir_sel;

    logic         reset2, im_gnt2, im_rvalid2;
    logic [31:0]  im_rdata2;
    logic         im_req2, if_valid2, redir_taken2;
    logic [31:0]  im_addr2, if_instr2, if_pc2;
    logic [2:0]   redir_sel2;

    int checks   = 0;
    int failures = 0;

    pc_fetch_ctrl dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redir_valid(redir_valid), .redir_target(redir_target),
        .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .redir_taken(redir_taken), .redir_sel(redir_sel)
    );

    pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset2), .stall(1'b0),
        .redir_valid(5'b0), .redir_target(160'b0),
        .im_req(im_req2), .im_addr(im_addr2), .im_gnt(im_gnt2),
        .im_rvalid(im_rvalid2), .im_rdata(im_rdata2),
        .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2),
        .redir_taken(redir_taken2), .redir_sel(redir_sel2)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_tgt(input int unsigned ch, input logic [31:0] t);
        redir_target[ch*32 +: 32] = t;
    endtask

    task automatic test_reset();
        reset = 1'b1; reset2 = 1'b1; stall = 1'b0;
        im_gnt = 1'b0; im_rvalid = 1'b0; im_rdata = '0;
        im_gnt2 = 1'b0; im_rvalid2 = 1'b0; im_rdata2 = '0;
        redir_target = '0; redir_valid = 5'b00110;
        tick(); tick();
        checks++; if (im_req !== 1'b1) begin failures++; $display("FAIL reset_req got=%b exp=1", im_req); end
        checks++; if (im_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", im_addr); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_ifvalid got=%b exp=0", if_valid); end
        checks++; if (if_instr !== 32'h0 || if_pc !== 32'h0) begin failures++; $display("FAIL reset_ifregs got=%h/%h exp=0/0", if_instr, if_pc); end
        checks++; if (redir_taken !== 1'b0 || redir_sel !== 3'd0) begin failures++; $display("FAIL reset_redir got=%b/%0d exp=0/0", redir_taken, redir_sel); end
        checks++; if (im_addr2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL reset_pc2 got=%h exp=fffffffc", im_addr2); end
        redir_valid = '0; reset = 1'b0; reset2 = 1'b0;
        tick();
    endtask

    task automatic test_sequential();
        for (int n = 0; n < 2; n++) begin
            checks++; if (im_req !== 1'b1 || im_addr !== 32'(4*n)) begin failures++; $display("FAIL seq_addr%0d got=%b/%h exp=1/%h", n, im_req, im_addr, 4*n); end
            im_gnt = 1'b1; tick(); im_gnt = 1'b0;
            checks++; if (im_req !== 1'b0) begin failures++; $display("FAIL seq_wait%0d got=%b exp=0", n, im_req); end
            im_rvalid = 1'b1; im_rdata = 32'hA0 + 32'(n); tick(); im_rvalid = 1'b0;
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4*n) || if_instr !== 32'hA0 + 32'(n)) begin
                failures++; $display("FAIL seq_out%0d got=%b/%h/%h exp=1/%h/%h", n, if_valid, if_pc, if_instr, 4*n, 32'hA0 + 32'(n)); end
            tick();
            checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL seq_oneshot%0d got=%b exp=0", n, if_valid); end
        end
    endtask

    task automatic test_stall();
        checks++; if (im_addr !== 32'h8) begin failures++; $display("FAIL stall_addr got=%h exp=8", im_addr); end
        im_gnt = 1'b1; tick(); im_gnt = 1'b0;
        im_rvalid = 1'b1; im_rdata = 32'hA2; stall = 1'b1; tick(); im_rvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'hA2 || im_req !== 1'b0) begin
                failures++; $display("FAIL stall_hold%0d got=%b/%h/%h/%b exp=1/8/a2/0", k, if_valid, if_pc, if_instr, im_req); end
            tick();
        end
        stall = 1'b0; tick();
        checks++; if (if_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'hC) begin
            failures++; $display("FAIL stall_release got=%b/%b/%h exp=0/1/c", if_valid, im_req, im_addr); end
    endtask

    task automatic test_redirect_drop();
        im_gnt = 1'b1; tick(); im_gnt = 1'b0;
        im_rvalid = 1'b1; im_rdata = 32'hA3; tick(); im_rvalid = 1'b0;
        checks++; if (if_pc !== 32'hC || if_instr !== 32'hA3) begin failures++; $display("FAIL drop_pre got=%h/%h exp=c/a3", if_pc, if_instr); end
        tick();
        checks++; if (im_addr !== 32'h10) begin failures++; $display("FAIL drop_addr got=%h exp=10", im_addr); end
        im_gnt = 1'b1; tick(); im_gnt = 1'b0;
        redir_valid = 5'b10000; set_tgt(REDIR_BRANCH, 32'h103); #1;
        checks++; if (redir_taken !== 1'b1 || redir_sel !== 3'd4) begin failures++; $display("FAIL drop_sel got=%b/%0d exp=1/4", redir_taken, redir_sel); end
        tick(); redir_valid = '0;
        checks++; if (im_addr !== 32'h100 || im_req !== 1'b0) begin failures++; $display("FAIL drop_newpc got=%h/%b exp=100/0", im_addr, im_req); end
        tick();
        im_rvalid = 1'b1; im_rdata = 32'hDEAD; tick(); im_rvalid = 1'b0;
        checks++; if (if_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h100) begin
            failures++; $display("FAIL drop_discard got=%b/%b/%h exp=0/1/100", if_valid, im_req, im_addr); end
        im_gnt = 1'b1; tick(); im_gnt = 1'b0;
        im_rvalid = 1'b1; im_rdata = 32'hB0; tick(); im_rvalid = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'hB0) begin
            failures++; $display("FAIL drop_refetch got=%b/%h/%h exp=1/100/b0", if_valid, if_pc, if_instr); end
        tick();
    endtask

    task automatic test_priority();
        checks++; if (im_addr !== 32'h104) begin failures++; $display("FAIL prio_addr got=%h exp=104", im_addr); end
        redir_valid = 5'b10100; set_tgt(REDIR_JUMP, 32'h200); set_tgt(REDIR_BRANCH, 32'h300);
        im_rvalid = 1'b1; im_rdata = 32'hBAD; #1;
        checks++; if (redir_taken !== 1'b1 || redir_sel !== 3'd2) begin failures++; $display("FAIL prio_sel got=%b/%0d exp=1/2", redir_taken, redir_sel); end
        tick(); redir_valid = '0; im_rvalid = 1'b0;
        checks++; if (im_addr !== 32'h200 || im_req !== 1'b1 || if_valid !== 1'b0) begin
            failures++; $display("FAIL prio_pc got=%h/%b/%b exp=200/1/0", im_addr, im_req, if_valid); end
    endtask

    task automatic test_hold_redirect();
        im_gnt = 1'b1; tick(); im_gnt = 1'b0;
        im_rvalid = 1'b1; im_rdata = 32'hC0; stall = 1'b1; tick(); im_rvalid = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin failures++; $display("FAIL hold_pre got=%b/%h exp=1/200", if_valid, if_pc); end
        redir_valid = 5'b00001; set_tgt(REDIR_ISR, 32'h80); #1;
        checks++; if (redir_taken !== 1'b1 || redir_sel !== 3'd0) begin failures++; $display("FAIL hold_sel got=%b/%0d exp=1/0", redir_taken, redir_sel); end
        tick(); redir_valid = '0; stall = 1'b0;
        checks++; if (if_valid !== 1'b0 || im_addr !== 32'h80 || im_req !== 1'b1) begin
            failures++; $display("FAIL hold_flush got=%b/%h/%b exp=0/80/1", if_valid, im_addr, im_req); end
    endtask

    task automatic test_back_to_back();
        im_gnt = 1'b1; redir_valid = 5'b01000; set_tgt(REDIR_JR, 32'h4F);
        tick(); im_gnt = 1'b0;
        checks++; if (im_addr !== 32'h4C || im_req !== 1'b0) begin failures++; $display("FAIL b2b_align got=%h/%b exp=4c/0", im_addr, im_req); end
        redir_valid = 5'b00010; set_tgt(REDIR_RETI, 32'h60);
        tick(); redir_valid = '0;
        checks++; if (im_addr !== 32'h60 || im_req !== 1'b0) begin failures++; $display("FAIL b2b_second got=%h/%b exp=60/0", im_addr, im_req); end
        im_rvalid = 1'b1; im_rdata = 32'hDEAD; tick(); im_rvalid = 1'b0;
        checks++; if (im_req !== 1'b1 || im_addr !== 32'h60 || if_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_discard got=%b/%h/%b exp=1/60/0", im_req, im_addr, if_valid); end
        im_gnt = 1'b1; tick(); im_gnt = 1'b0;
        im_rvalid = 1'b1; im_rdata = 32'hD0; tick(); im_rvalid = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h60 || if_instr !== 32'hD0) begin
            failures++; $display("FAIL b2b_fetch got=%b/%h/%h exp=1/60/d0", if_valid, if_pc, if_instr); end
        tick();
    endtask

    task automatic test_reset_mid();
        im_gnt = 1'b1; redir_valid = 5'b00100; set_tgt(REDIR_JUMP, 32'h300);
        tick(); im_gnt = 1'b0; redir_valid = '0;
        checks++; if (im_req !== 1'b0 || im_addr !== 32'h300) begin failures++; $display("FAIL rmid_wait got=%b/%h exp=0/300", im_req, im_addr); end
        reset = 1'b1; redir_valid = 5'b00001; #1;
        checks++; if (redir_taken !== 1'b0 || redir_sel !== 3'd0) begin failures++; $display("FAIL rmid_redir got=%b/%0d exp=0/0", redir_taken, redir_sel); end
        tick(); reset = 1'b0; redir_valid = '0;
        checks++; if (im_req !== 1'b1 || im_addr !== 32'h0 || if_valid !== 1'b0) begin
            failures++; $display("FAIL rmid_state got=%b/%h/%b exp=1/0/0", im_req, im_addr, if_valid); end
        im_gnt = 1'b1; tick(); im_gnt = 1'b0;
        im_rvalid = 1'b1; im_rdata = 32'hE0; tick(); im_rvalid = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hE0) begin
            failures++; $display("FAIL rmid_nodrop got=%b/%h/%h exp=1/0/e0", if_valid, if_pc, if_instr); end
        tick();
    endtask

    task automatic test_wrap();
        for (int n = 0; n < 2; n++) begin
            logic [31:0] e;
            e = 32'hFFFF_FFFC + 32'(4*n);
            checks++; if (im_req2 !== 1'b1 || im_addr2 !== e) begin failures++; $display("FAIL wrap_addr%0d got=%b/%h exp=1/%h", n, im_req2, im_addr2, e); end
            im_gnt2 = 1'b1; tick(); im_gnt2 = 1'b0;
            im_rvalid2 = 1'b1; im_rdata2 = 32'h50 + 32'(n); tick(); im_rvalid2 = 1'b0;
            checks++; if (if_valid2 !== 1'b1 || if_pc2 !== e || if_instr2 !== 32'h50 + 32'(n)) begin
                failures++; $display("FAIL wrap_out%0d got=%b/%h/%h exp=1/%h/%h", n, if_valid2, if_pc2, if_instr2, e, 32'h50 + 32'(n)); end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drop();
        test_priority();
        test_hold_redirect();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
